fetch_slot_filter: RTL
======================

// Module: fetch_slot_filter
// PURPOSE
// - Decode-side consumer of the frontend fetch stream (pc, slot id, instr word, exc).
// - Drops stale replay copies by monotonic slot-id ordering and buffers accepted
//   instructions in a small FIFO with valid/ready handshake to decode.
// - Raises stall_req early enough to absorb the two in-flight frontend stages.
// PARAMETERS
// - DEPTH  4  FIFO entries; power of two, >= SKID+2
// - SKID   2  entries reserved for in-flight fetch words after stall_req asserts
// PORTS
// - clk        in   1   clock
// - rst_n      in   1   reset, synchronous, active-low
// - clk_en     in   1   global clock enable; all state holds when low
// - flush      in   1   redirect (branch/interrupt/rfe); kills buffer and slot base
// - in_valid   in   1   frontend word valid (inverse of fetch bubble)
// - in_pc      in   32  fetch PC
// - in_slot_id in   32  fetch slot id
// - in_instr   in   32  instruction word
// - in_exc     in   8   fetch exception code (0 = none)
// - out_valid  out  1   FIFO head valid
// - out_ready  in   1   decode accepts head this cycle
// - out_pc, out_slot_id, out_instr  out 32 each  head entry fields
// - out_exc    out  8   head entry exception
// - stall_req  out  1   frontend stall request
// - dup_drop   out  1   one-cycle pulse: stale replay discarded
// - ovf        out  1   sticky: accepted word lost because FIFO full
// - gap_err    out  1   one-cycle pulse: slot id skipped (SLOT_GAP_CHECK_EN only)
// BEHAVIOUR
// - Reset (rst_n=0 at posedge, regardless of clk_en): count=0, have_base=0,
//   next_slot=0, out_valid=0, stall_req=0, dup_drop=0, ovf=0, gap_err=0.
// - Classification when in_valid && !flush: d = in_slot_id - next_slot, 32-bit signed.
//   !have_base -> accept, have_base<=1, next_slot<=in_slot_id+1.
//   d<0 -> stale: drop, dup_drop pulse, next_slot unchanged.
//   d==0 -> accept, next_slot<=next_slot+1.
//   d>0 -> gap: accept, next_slot<=in_slot_id+1.
// - Signed difference makes ordering correct across 32-bit wrap.
// - Push: accepted word written at tail iff count<DEPTH or pop this cycle.
//   Otherwise lost, ovf<=1 (sticky until reset).
// - Pop: out_valid && out_ready; head advances.
// - Simultaneous push+pop: count unchanged, including at DEPTH.
// - out_valid = (count!=0). No bypass: accepted word appears on out_* the cycle after push.
// - stall_req registered: next count >= DEPTH-SKID.
// - flush (priority over push/pop): count<=0, pointers<=0, have_base<=0.
//   Input word that cycle discarded; no dup_drop. out_valid=0 next cycle.
// - clk_en=0: no push/pop/classification; pulses deassert next enabled edge only.
// - Exception entries (in_exc!=0) are classified and buffered like normal words.
// CONFIGURATION
// - SLOT_GAP_CHECK_EN defined: gap_err pulses one cycle on every d>0 accept
//   (not on base accept).
// - Undefined: gap logic not built, gap_err tied 0; data path identical.
// STRUCTURE
// - frontend_pkg: SLOT_W=32, PC_W=32, EXC_W=8; fetch_entry_t {pc, slot_id, instr, exc}.
// - Sub-module slot_fifo: DEPTH-entry fetch_entry_t FIFO, push/pop/clear, count.
// - Top: classifier, next_slot/have_base regs, stall_req, flags.
// TESTING
// - Reset, ready=1, in slots 0,1,2 back-to-back -> out slots 0,1,2 each one cycle
//   later; dup_drop never asserted.
// - Replay shape 10,11,12,10,10,11,12,13 -> out 10,11,12,13 only; dup_drop pulses 4 times.
// - ready=0, push 3 entries, flush -> out_valid=0 next cycle; next in slot 40 accepted
//   as base, out_slot_id=40.
// - DEPTH=4, ready=0: push 0,1 -> stall_req=1 after second push; push 2,3 accepted;
//   push 4 -> ovf=1, FIFO holds 0..3.
// - Wrap: 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0xFFFFFFFF -> first three output, last dropped.
// - 3 then 5: macro defined -> gap_err one pulse, 5 output; undefined -> gap_err=0.

Source files
------------

// File: rtl/frontend_pkg.sv
// rtl/frontend_pkg.sv - shared fetch-entry types and slot classification helper
package frontend_pkg;

    localparam int SLOT_W  = 32;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int EXC_W   = 8;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [SLOT_W-1:0]  slot_id;
        logic [INSTR_W-1:0] instr;
        logic [EXC_W-1:0]   exc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        SLOT_BASE  = 2'd0,
        SLOT_STALE = 2'd1,
        SLOT_NEXT  = 2'd2,
        SLOT_GAP   = 2'd3
    } slot_class_e;

    // Ordering uses the signed difference so it stays correct across 32-bit wrap.
    function automatic slot_class_e classify_slot(
        input logic              have_base,
        input logic [SLOT_W-1:0] slot_id,
        input logic [SLOT_W-1:0] next_slot
    );
        logic signed [SLOT_W-1:0] diff;
        diff = signed'(slot_id - next_slot);
        if (!have_base) begin
            return SLOT_BASE;
        end else if (diff < 0) begin
            return SLOT_STALE;
        end else if (diff == 0) begin
            return SLOT_NEXT;
        end else begin
            return SLOT_GAP;
        end
    endfunction

endpackage

// File: rtl/slot_fifo.sv
// rtl/slot_fifo.sv - DEPTH-entry fetch entry FIFO with push/pop/clear and count
module slot_fifo
    import frontend_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     wr_data,
    output fetch_entry_t     rd_data,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and count update; clear wins over any push/pop in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State registers; storage contents are don't-care after reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data    = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/fetch_slot_filter.sv
// rtl/fetch_slot_filter.sv - stale-replay filter and decode buffer; option macro SLOT_GAP_CHECK_EN
module fetch_slot_filter
    import frontend_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SKID  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [SLOT_W-1:0]  in_slot_id,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [EXC_W-1:0]   in_exc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [SLOT_W-1:0]  out_slot_id,
    output logic [INSTR_W-1:0] out_instr,
    output logic [EXC_W-1:0]   out_exc,
    output logic               stall_req,
    output logic               dup_drop,
    output logic               ovf,
    output logic               gap_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - SKID);

    logic              have_base_q, have_base_d;
    logic [SLOT_W-1:0] next_slot_q, next_slot_d;
    logic              stall_req_q, stall_req_d;
    logic              dup_drop_q, dup_drop_d;
    logic              ovf_q, ovf_d;

    slot_class_e       slot_class;
    logic              fire, accept, push, pop, clear, lost;
    fetch_entry_t      wr_entry, head;
    logic [CNT_W-1:0]  count, count_next;

    assign wr_entry = '{pc: in_pc, slot_id: in_slot_id, instr: in_instr, exc: in_exc};

    // Classify the incoming word and derive FIFO controls; flush overrides everything.
    always_comb begin
        slot_class = classify_slot(have_base_q, in_slot_id, next_slot_q);
        fire       = clk_en && in_valid && !flush;
        pop        = clk_en && !flush && out_valid && out_ready;
        clear      = clk_en && flush;
        accept     = fire && (slot_class != SLOT_STALE);
        push       = accept && ((count != FULL_CNT) || pop);
        lost       = accept && !push;
    end

    // Slot ordering state and status flags; everything holds while clk_en is low.
    always_comb begin
        have_base_d = have_base_q;
        next_slot_d = next_slot_q;
        stall_req_d = stall_req_q;
        dup_drop_d  = dup_drop_q;
        ovf_d       = ovf_q | lost;
        if (clk_en) begin
            stall_req_d = (count_next >= STALL_CNT);
            dup_drop_d  = fire && (slot_class == SLOT_STALE);
            if (flush) begin
                have_base_d = 1'b0;
                next_slot_d = '0;
            end else if (fire) begin
                case (slot_class)
                    SLOT_BASE: begin
                        have_base_d = 1'b1;
                        next_slot_d = in_slot_id + 1'b1;
                    end
                    SLOT_NEXT:  next_slot_d = next_slot_q + 1'b1;
                    SLOT_GAP:   next_slot_d = in_slot_id + 1'b1;
                    default:    next_slot_d = next_slot_q;
                endcase
            end
        end
    end

    // Registers for ordering state and flags; reset ignores clk_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            have_base_q <= 1'b0;
            next_slot_q <= '0;
            stall_req_q <= 1'b0;
            dup_drop_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            have_base_q <= have_base_d;
            next_slot_q <= next_slot_d;
            stall_req_q <= stall_req_d;
            dup_drop_q  <= dup_drop_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef SLOT_GAP_CHECK_EN
    logic gap_err_q, gap_err_d;

    // Pulse when a word skips ahead of the expected slot (base accepts excluded).
    always_comb begin
        gap_err_d = gap_err_q;
        if (clk_en) begin
            gap_err_d = fire && (slot_class == SLOT_GAP);
        end
    end

    // Gap pulse register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_err_q <= 1'b0;
        end else begin
            gap_err_q <= gap_err_d;
        end
    end

    assign gap_err = gap_err_q;
`else
    assign gap_err = 1'b0;
`endif

    slot_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .clear      (clear),
        .wr_data    (wr_entry),
        .rd_data    (head),
        .count      (count),
        .count_next (count_next)
    );

    assign out_valid   = (count != '0);
    assign out_pc      = head.pc;
    assign out_slot_id = head.slot_id;
    assign out_instr   = head.instr;
    assign out_exc     = head.exc;
    assign stall_req   = stall_req_q;
    assign dup_drop    = dup_drop_q;
    assign ovf         = ovf_q;

endmodule
